// File: rtl/pattern_moore.sv
// Moore-style serial pattern detector; the next-state table is built at elaboration from PATTERN.
// Optional saturating match counter enabled by defining PATTERN_MOORE_COUNT_EN.
module pattern_moore #(
  parameter int                     PATTERN_LEN = 2,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  output logic       y
`ifdef PATTERN_MOORE_COUNT_EN
  ,
  output logic [7:0] match_count
`endif
);

  localparam int SW = $clog2(PATTERN_LEN + 1);
  localparam logic [SW-1:0] LAST = SW'(PATTERN_LEN);

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
  function automatic int calc_next(input int k, input bit b);
    bit pat [8];
    bit seq [9];
    int n;
    int best;
    bit ok;
    for (int i = 0; i < 8; i++) pat[i] = 1'b0;
    for (int i = 0; i < 9; i++) seq[i] = 1'b0;
    for (int i = 0; i < PATTERN_LEN; i++) pat[i] = PATTERN[PATTERN_LEN-1-i];
    for (int i = 0; i < k; i++) seq[i] = pat[i];
    seq[k] = b;
    n = k + 1;
    best = 0;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      if (j <= n) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          if (seq[n-j+m] != pat[m]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;
  logic          y_reg;
  logic [SW-1:0] tab0 [PATTERN_LEN+1];
  logic [SW-1:0] tab1 [PATTERN_LEN+1];

  genvar gi;
  generate
    for (gi = 0; gi <= PATTERN_LEN; gi++) begin : g_tab
      localparam int N0 = calc_next(gi, 1'b0);
      localparam int N1 = calc_next(gi, 1'b1);
      assign tab0[gi] = SW'(N0);
      assign tab1[gi] = SW'(N1);
    end
  endgenerate

  // Unreachable encodings fall back to the idle state.
  always_comb begin
    state_next = '0;
    for (int k = 0; k <= PATTERN_LEN; k++) begin
      if (state == SW'(k)) state_next = a ? tab1[k] : tab0[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      y_reg <= 1'b0;
    end else begin
      state <= state_next;
      y_reg <= (state_next == LAST);
    end
  end

  assign y = y_reg;

`ifdef PATTERN_MOORE_COUNT_EN
  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 8'd0;
    end else if ((state_next == LAST) && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign match_count = count_reg;
`endif

  a_known : assert property (@(posedge clk) disable iff (!reset) !$isunknown(a));

endmodule

// File: tb/tb_pattern_moore.sv
// Scoreboard bench for pattern_moore: a default (01) and a 3-bit (101) instance share one input stream.
module tb_pattern_moore;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0;
  logic y2;
  logic y3;
`ifdef PATTERN_MOORE_COUNT_EN
  logic [7:0] cnt2;
  logic [7:0] cnt3;
`endif

  always #5 clk = ~clk;

  pattern_moore dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .y(y2)
`ifdef PATTERN_MOORE_COUNT_EN
    ,
    .match_count(cnt2)
`endif
  );

  pattern_moore #(.PATTERN_LEN(3), .PATTERN(3'b101)) dut3 (
    .clk(clk),
    .reset(reset),
    .a(a),
    .y(y3)
`ifdef PATTERN_MOORE_COUNT_EN
    ,
    .match_count(cnt3)
`endif
  );

  typedef struct {
    int st2;
    int st3;
    int y2;
    int y3;
    int cnt2;
    int cnt3;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  int   cnt2_m = 0;
  int   cnt3_m = 0;
  int   checks = 0;
  int   fails = 0;

  // Longest k such that the last k received bits equal the first k pattern bits.
  function automatic int model_state(input int len, input logic [7:0] pat);
    int n;
    bit ok;
    n = hist.size();
    for (int k = len; k >= 1; k--) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int m = 0; m < k; m++) begin
          if (hist[n-k+m] != pat[len-1-m]) ok = 1'b0;
        end
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic do_cycle(input bit b, input bit rst_n);
    exp_t e;
    @(negedge clk);
    reset = rst_n;
    a = b;
    if (!rst_n) begin
      hist.delete();
      cnt2_m = 0;
      cnt3_m = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    e.st2 = model_state(2, 8'b01);
    e.st3 = model_state(3, 8'b101);
    e.y2 = (e.st2 == 2) ? 1 : 0;
    e.y3 = (e.st3 == 3) ? 1 : 0;
    if (rst_n) begin
      if (e.st2 == 2 && cnt2_m < 255) cnt2_m++;
      if (e.st3 == 3 && cnt3_m < 255) cnt3_m++;
    end
    e.cnt2 = cnt2_m;
    e.cnt3 = cnt3_m;
    sb.push_back(e);
    $display("cycle t=%0t reset=%0b a=%0b exp_st2=%0d exp_y2=%0d exp_st3=%0d exp_y3=%0d",
             $time, rst_n, b, e.st2, e.y2, e.st3, e.y3);
  endtask

  // Mid-cycle reset assertion must clear state without waiting for a clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_state_p01", int'(dut.state), 0);
    check("async_y_p01", int'(y2), 0);
    check("async_state_p101", int'(dut3.state), 0);
    check("async_y_p101", int'(y3), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state_p01", int'(dut.state), e.st2);
        check("y_p01", int'(y2), e.y2);
        check("state_p101", int'(dut3.state), e.st3);
        check("y_p101", int'(y3), e.y3);
`ifdef PATTERN_MOORE_COUNT_EN
        check("count_p01", int'(cnt2), e.cnt2);
        check("count_p101", int'(cnt3), e.cnt3);
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    bit seq24 [12];
    bit seq25 [5];
    seq24 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    seq25 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Held reset with toggling input
    for (int i = 0; i < 3; i++) do_cycle(bit'(i & 1), 1'b0);

    // Basic detect: 0,0,1,1
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b1, 1'b1);
    do_cycle(1'b1, 1'b1);

    // Repeated two-cycle-per-bit sequence
    for (int i = 0; i < 12; i++) begin
      do_cycle(seq24[i], 1'b1);
      do_cycle(seq24[i], 1'b1);
    end

    // Overlap on the 101 instance after a fresh reset
    do_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_cycle(seq25[i], 1'b1);

    // Mid-pattern reset discards the leading 0
    do_cycle(1'b0, 1'b1);
    async_reset_check();
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b1);
    do_cycle(1'b0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      do_cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 49) != 0));
    end

    // Long 0,1 run to saturate the counter
    do_cycle(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'b0, 1'b1);
      do_cycle(1'b1, 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
`ifdef PATTERN_MOORE_COUNT_EN
    check("count_saturated_p01", int'(cnt2), 255);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pattern_moore.md
PATTERN_MOORE -- requirements
Module: pattern_moore

Interface
REQ-001 The block SHALL have parameter PATTERN_LEN, default 2, giving the pattern length in bits; legal range 1..8.
REQ-002 The block SHALL have parameter PATTERN, default 2'b01, PATTERN_LEN bits wide; MSB is the first bit received, LSB the last.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port a, input, 1 bit, serial data bit sampled on each rising clk edge.
REQ-006 The block SHALL have port y, output, 1 bit, Moore match flag.
REQ-007 The block SHALL have port match_count, output, 8 bits, saturating match counter; present only when PATTERN_MOORE_COUNT_EN is defined.

Function
REQ-008 The block SHALL hold an internal state register named state, width clog2(PATTERN_LEN+1), probeable hierarchically.
REQ-009 The state value k (0..PATTERN_LEN) SHALL mean that the last k received bits equal the first k bits of PATTERN.
REQ-010 On each rising clk edge outside reset, the next state SHALL be the longest k such that the last k bits (including current a) equal the first k PATTERN bits; overlapping matches are detected.
REQ-011 With default parameters the transitions SHALL be: S0: a=0->S1, a=1->S0; S1: a=0->S1, a=1->S2; S2: a=0->S1, a=1->S0.
REQ-012 The next-state computation SHALL be combinational from state and a, derived at elaboration from PATTERN.
REQ-013 y SHALL be 1 exactly when state == PATTERN_LEN, decoded from state only; it SHALL NOT depend combinationally on a.
REQ-014 y SHALL rise in the clock cycle following the rising edge that sampled the last pattern bit (one-cycle latency) and stay high for one cycle per match unless the next bit extends an overlapping match.
REQ-015 X or Z on a SHALL be treated as not-matching-any-bit only in simulation assertions; the RTL SHALL not add special handling.

Reset
REQ-016 While reset is 0, state SHALL be forced to 0 immediately (asynchronously) and y SHALL read 0.
REQ-017 Deassertion of reset SHALL be honoured at the next rising clk edge; the first bit sampled after deassertion SHALL start a fresh match.
REQ-018 Reset asserted mid-pattern SHALL discard all partial match history.
REQ-019 match_count (when present) SHALL reset asynchronously to 0.

Configuration
REQ-020 When macro PATTERN_MOORE_COUNT_EN is defined, match_count SHALL increment by 1 on each rising edge whose next state is PATTERN_LEN, saturating at 255.
REQ-021 When PATTERN_MOORE_COUNT_EN is not defined, match_count and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Reset: hold reset=0 with a toggling for 3 cycles -> state=0, y=0 throughout; match_count=0.
REQ-023 Basic detect (defaults): after reset release, a=0 for 2 cycles, then a=1 -> state goes S1 then S2; y=1 for the cycle after a=1 is sampled, then a=1 again -> S0, y=0.
REQ-024 Repeated input sequence 0,0,1,1,0,0,1,1,1,1,0,0 (two cycles each bit) -> y pulses exactly twice, each one cycle wide, after each 0->1 transition.
REQ-025 Overlap: PATTERN_LEN=3, PATTERN=3'b101, input 1,0,1,0,1 -> y high after 3rd and 5th bits.
REQ-026 Mid-pattern reset: input 0 then assert reset before the 1 -> after release, a single 1 gives y=0.
REQ-027 With PATTERN_MOORE_COUNT_EN: 300 consecutive 0,1 pairs -> match_count saturates at 255 and holds.
